// File: rtl/conv_result_streamer.sv
// conv_result_streamer
//   Reader end of the convolution core's flat result bus. A rising edge on
//   `start` (wired to the core's `done`) snapshots the whole OUT x OUT result
//   image. The snapshot is then replayed as a raster-order pixel stream over a
//   valid/ready handshake, starting at row 0 col 0. Once the snapshot is taken,
//   the core may begin its next frame.
//
//   Optional feature: define CONV_STREAM_CHECKSUM_EN to add a 32-bit running
//   sum of the streamed pixels on port `checksum`.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           level input; only its rising edge triggers a frame
//   result          flat bus, pixel (r,c) at [(r*OUT+c)*PIX_W +: PIX_W]
//   busy            high from the cycle after capture through frame_done
//   m_valid/m_ready stream handshake
//   m_data          current pixel
//   m_row/m_col     position of the current pixel
//   m_sof/m_eol/m_last  framing: first pixel / end of row / last pixel
//   frame_done      one-cycle pulse after the last beat transfers
//   checksum        (CONV_STREAM_CHECKSUM_EN only) sum of transferred pixels
module conv_result_streamer #(
  parameter  int OUT   = 126,
  parameter  int PIX_W = 16,
  localparam int IDX_W = (OUT > 1) ? $clog2(OUT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [OUT*OUT*PIX_W-1:0] result,
  output logic                     busy,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [PIX_W-1:0]         m_data,
  output logic [IDX_W-1:0]         m_row,
  output logic [IDX_W-1:0]         m_col,
  output logic                     m_sof,
  output logic                     m_eol,
  output logic                     m_last,
  output logic                     frame_done
`ifdef CONV_STREAM_CHECKSUM_EN
  ,
  output logic [31:0]              checksum
`endif
);

  localparam int NPIX  = OUT * OUT;
  localparam int LIN_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(OUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                      state, state_n;
  logic                        start_d;
  logic                        trig;
  logic                        capture;
  logic                        xfer;
  logic                        at_eol;
  logic                        at_last;
  logic [IDX_W-1:0]            row, col;
  // Linear pixel index tracks row*OUT+col so the read mux needs no multiplier.
  logic [LIN_W-1:0]            lin;
  logic [NPIX-1:0][PIX_W-1:0]  frame;

  assign trig    = start & ~start_d;
  assign xfer    = (state == STREAM) & m_ready;
  assign at_eol  = (col == IDX_MAX);
  assign at_last = at_eol & (row == IDX_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      start_d <= 1'b0;
    end else begin
      state   <= state_n;
      start_d <= start;
    end
  end

  // Next state plus all outputs; every m_* is forced to zero outside STREAM
  // so that reset and idle both present an all-zero interface.
  always_comb begin
    state_n    = state;
    capture    = 1'b0;
    busy       = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_row      = '0;
    m_col      = '0;
    m_sof      = 1'b0;
    m_eol      = 1'b0;
    m_last     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          capture = 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_data  = frame[lin];
        m_row   = row;
        m_col   = col;
        m_sof   = (lin == '0);
        m_eol   = at_eol;
        m_last  = at_last;
        if (xfer && at_last) state_n = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
      lin <= '0;
    end else if (capture) begin
      row <= '0;
      col <= '0;
      lin <= '0;
    end else if (xfer) begin
      lin <= lin + 1'b1;
      if (at_eol) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Snapshot only; contents are don't-care until the first capture.
  always_ff @(posedge clk) begin
    if (capture) frame <= result;
  end

`ifdef CONV_STREAM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)          checksum <= '0;
    else if (capture) checksum <= '0;
    else if (xfer)    checksum <= checksum + 32'(m_data);
  end
`endif

endmodule

// File: tb/tb_conv_result_streamer.sv
module tb_conv_result_streamer;
  localparam int OUT   = 3;
  localparam int PIX_W = 16;
  localparam int IDX_W = 2;
  localparam int NPIX  = OUT * OUT;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [NPIX*PIX_W-1:0]    result;
  logic                     busy, m_valid, m_ready;
  logic [PIX_W-1:0]         m_data;
  logic [IDX_W-1:0]         m_row, m_col;
  logic                     m_sof, m_eol, m_last, frame_done;
`ifdef CONV_STREAM_CHECKSUM_EN
  logic [31:0]              checksum;
`endif

  int checks   = 0;
  int failures = 0;

  int exp_pix [NPIX] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};

  conv_result_streamer #(.OUT(OUT), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .result(result),
    .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_sof(m_sof), .m_eol(m_eol),
    .m_last(m_last), .frame_done(frame_done)
`ifdef CONV_STREAM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are inspected and inputs changed 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_result();
    for (int i = 0; i < NPIX; i++) result[i*PIX_W +: PIX_W] = PIX_W'(exp_pix[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b1; load_result();
    step(); step();
    checks++;
    if ({busy, m_valid, m_data, m_row, m_col, m_sof, m_eol, m_last, frame_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b valid=%b data=%0d row=%0d col=%0d sof=%b eol=%b last=%b done=%b, required all 0",
               busy, m_valid, m_data, m_row, m_col, m_sof, m_eol, m_last, frame_done);
    end
`ifdef CONV_STREAM_CHECKSUM_EN
    checks++;
    if (checksum !== 32'd0) begin
      failures++; $display("FAIL reset_checksum: got %0d, required 0", checksum);
    end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    start = 1'b1;
    step();
    for (int b = 0; b < NPIX; b++) begin
      checks++;
      if (m_valid !== 1'b1 || busy !== 1'b1 || m_data !== PIX_W'(exp_pix[b]) ||
          m_row !== IDX_W'(b / OUT) || m_col !== IDX_W'(b % OUT) ||
          m_sof !== (b == 0) || m_eol !== (b % OUT == OUT - 1) ||
          m_last !== (b == NPIX - 1) || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL nominal_beat%0d: valid=%b busy=%b data=%0d row=%0d col=%0d sof=%b eol=%b last=%b done=%b, required data=%0d row=%0d col=%0d sof=%b eol=%b last=%b",
                 b, m_valid, busy, m_data, m_row, m_col, m_sof, m_eol, m_last, frame_done,
                 exp_pix[b], b / OUT, b % OUT, b == 0, b % OUT == OUT - 1, b == NPIX - 1);
      end
      step();
    end
    checks++;
    if (frame_done !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL nominal_done: done=%b valid=%b busy=%b, required 1 0 1", frame_done, m_valid, busy);
    end
`ifdef CONV_STREAM_CHECKSUM_EN
    checks++;
    if (checksum !== 32'd1053) begin
      failures++; $display("FAIL nominal_checksum: got %0d, required 1053", checksum);
    end
`endif
    step();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL nominal_idle: done=%b busy=%b valid=%b, required 0 0 0", frame_done, busy, m_valid);
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    start = 1'b1;
    step();
    for (int b = 0; b < NPIX; b++) begin
      if (b == 3) begin
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          step();
          checks++;
          if (m_valid !== 1'b1 || m_data !== 16'd108 || m_row !== 2'd1 || m_col !== 2'd0) begin
            failures++;
            $display("FAIL stall_hold%0d: valid=%b data=%0d row=%0d col=%0d, required 1 108 1 0",
                     k, m_valid, m_data, m_row, m_col);
          end
        end
        m_ready = 1'b1;
      end
      checks++;
      if (m_valid !== 1'b1 || m_data !== PIX_W'(exp_pix[b])) begin
        failures++;
        $display("FAIL stall_beat%0d: valid=%b data=%0d, required 1 %0d", b, m_valid, m_data, exp_pix[b]);
      end
      step();
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++; $display("FAIL stall_done: done=%b, required 1", frame_done);
    end
    start = 1'b0;
    step(); step();
  endtask

  task automatic test_level_start();
    for (int f = 0; f < 2; f++) begin
      int beats = 0;
      int dones = 0;
      int bad   = 0;
      start = 1'b1;
      for (int cyc = 0; cyc < (f == 0 ? 40 : 15); cyc++) begin
        step();
        if (m_valid) begin
          if (beats >= NPIX || m_data !== PIX_W'(exp_pix[beats % NPIX])) bad++;
          beats++;
        end
        if (frame_done) dones++;
      end
      checks++;
      if (beats != NPIX || dones != 1 || bad != 0) begin
        failures++;
        $display("FAIL level_frame%0d: beats=%0d dones=%0d bad_data=%0d, required 9 1 0", f, beats, dones, bad);
      end
      start = 1'b0;
      step();
    end
    step();
  endtask

  task automatic test_snapshot();
    start = 1'b1;
    step();
    for (int b = 0; b < NPIX; b++) begin
      if (b == 2) result = '1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== PIX_W'(exp_pix[b])) begin
        failures++;
        $display("FAIL snapshot_beat%0d: valid=%b data=%0d, required 1 %0d", b, m_valid, m_data, exp_pix[b]);
      end
      step();
    end
    start = 1'b0;
    load_result();
    step(); step();
  endtask

  task automatic test_reset_midframe();
    int dones = 0;
    int vlds  = 0;
    bit seen  = 0;
    start = 1'b1;
    step();
    for (int b = 0; b < 4; b++) step();
    checks++;
    if (m_data !== 16'd117) begin
      failures++; $display("FAIL rstmid_beat5: data=%0d, required 117", m_data);
    end
    rst = 1'b1; start = 1'b0;
    step();
    checks++;
    if ({busy, m_valid, m_data, m_row, m_col, m_sof, m_eol, m_last, frame_done} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: busy=%b valid=%b data=%0d row=%0d col=%0d sof=%b eol=%b last=%b done=%b, required all 0",
               busy, m_valid, m_data, m_row, m_col, m_sof, m_eol, m_last, frame_done);
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (frame_done) dones++;
      if (m_valid) vlds++;
    end
    checks++;
    if (dones != 0 || vlds != 0) begin
      failures++; $display("FAIL rstmid_quiet: dones=%0d valids=%0d, required 0 0", dones, vlds);
    end
    start = 1'b1;
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'd63 || m_row !== 2'd0 || m_col !== 2'd0 || m_sof !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_restart: valid=%b data=%0d row=%0d col=%0d sof=%b, required 1 63 0 0 1",
               m_valid, m_data, m_row, m_col, m_sof);
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (frame_done) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL rstmid_drain: frame_done seen=%0d, required 1 within 20 cycles", seen);
    end
    start = 1'b0;
    step(); step();
  endtask

`ifdef CONV_STREAM_CHECKSUM_EN
  task automatic test_checksum();
    bit seen = 0;
    start = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (frame_done) seen = 1;
    end
    checks++;
    if (!seen || checksum !== 32'd1053) begin
      failures++; $display("FAIL cksum_final: seen=%0d checksum=%0d, required 1 1053", seen, checksum);
    end
    start = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (checksum !== 32'd1053) begin
      failures++; $display("FAIL cksum_hold: got %0d, required 1053", checksum);
    end
    start = 1'b1;
    step();
    checks++;
    if (checksum !== 32'd0) begin
      failures++; $display("FAIL cksum_clear: got %0d, required 0", checksum);
    end
    for (int c = 0; c < 12; c++) step();
    start = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_level_start();
    test_snapshot();
    test_reset_midframe();
`ifdef CONV_STREAM_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
